multi_channel_gated_counter: RTL and testbench

// - Parametrised multi-channel gated edge counter for the frequency meter datapath.
// - Counts input-signal edges on NUM_CH channels, but only while the common gate window is high.
// - Latches the per-channel counts and overflow flags when the gate closes, then pulses result_valid.
// - Sits between the gate-time generator and the frequency computation / readout logic.

---
 rtl/multi_channel_gated_counter.sv | 116 +++++++++++
 tb/tb_multi_channel_gated_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_gated_counter.sv
// Gated multi-channel edge counter: counts sig_in edges while gate is high, latches counts/ovf at gate close.
// Latency: result 1 clk after gate falls; MULTI_CHANNEL_GATED_COUNTER_SYNC_EN adds 2 clk on sig_in. Backpressure: none.
module multi_channel_gated_counter #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 32,
  parameter int EDGE_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gate,
  input  logic [NUM_CH-1:0]         sig_in,
  output logic [NUM_CH*WIDTH-1:0]   count_out,
  output logic [NUM_CH-1:0]         ovf_out,
  output logic                      result_valid,
  output logic                      busy
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] w_sig;
  logic [NUM_CH-1:0] r_sig_prev;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_edge;
  logic              r_gate_prev;
  logic              r_result_valid;
  logic              w_open;
  logic              w_run;
  logic              w_close;

`ifdef MULTI_CHANNEL_GATED_COUNTER_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sig = r_sync2;
`else
  assign w_sig = sig_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_prev     <= '0;
      r_gate_prev    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_sig_prev     <= w_sig;
      r_gate_prev    <= gate;
      r_result_valid <= w_close;
    end
  end

  assign w_rise  = w_sig & ~r_sig_prev;
  assign w_fall  = ~w_sig & r_sig_prev;
  assign w_open  = gate & ~r_gate_prev;
  assign w_run   = gate & r_gate_prev;
  assign w_close = ~gate & r_gate_prev;

  always_comb begin
    w_edge = '0;
    case (EDGE_MODE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise | w_fall;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;
    logic             r_ovf_res;

    // Open reloads the counter with this cycle's edge so the first gated cycle is not lost.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
        r_res     <= '0;
        r_ovf_res <= 1'b0;
      end else begin
        if (w_open) begin
          r_cnt <= w_edge[i] ? CNT_ONE : '0;
          r_ovf <= 1'b0;
        end else if (w_run && w_edge[i]) begin
          if (r_cnt == CNT_MAX) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        if (w_close) begin
          r_res     <= r_cnt;
          r_ovf_res <= r_ovf;
        end
      end
    end

    assign count_out[i*WIDTH +: WIDTH] = r_res;
    assign ovf_out[i]                  = r_ovf_res;
  end

  assign result_valid = r_result_valid;
  assign busy         = r_gate_prev;

endmodule

// File: tb/tb_multi_channel_gated_counter.sv
// Random and directed windows on four counter variants, checked every cycle against a window-level edge tally.
module tb_multi_channel_gated_counter;

  localparam int NCH = 4;
  localparam int D_MODE [4] = '{0, 1, 2, 0};
  localparam longint D_MAX [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  logic         clk = 1'b0;
  logic         rst;
  logic         gate;
  logic [3:0]   sig_in;
  logic [127:0] cnt0, cnt1, cnt2;
  logic [15:0]  cnt3;
  logic [3:0]   ovf0, ovf1, ovf2, ovf3;
  logic         rv0, rv1, rv2, rv3;
  logic         bz0, bz1, bz2, bz3;

  int n_cmp = 0;
  int n_err = 0;

  int     m_win [3][NCH];
  longint exp_cnt [4][NCH];
  bit     exp_ovf [4][NCH];
  bit     exp_rv;
  bit     exp_busy;
  bit     m_gprev;
  logic [3:0] m_sprev;
  logic [3:0] m_h1, m_h2;

  always #5 clk = ~clk;

  multi_channel_gated_counter #(.NUM_CH(4), .WIDTH(32), .EDGE_MODE(0)) u_rise (
    .clk(clk), .rst(rst), .gate(gate), .sig_in(sig_in),
    .count_out(cnt0), .ovf_out(ovf0), .result_valid(rv0), .busy(bz0));
  multi_channel_gated_counter #(.NUM_CH(4), .WIDTH(32), .EDGE_MODE(1)) u_fall (
    .clk(clk), .rst(rst), .gate(gate), .sig_in(sig_in),
    .count_out(cnt1), .ovf_out(ovf1), .result_valid(rv1), .busy(bz1));
  multi_channel_gated_counter #(.NUM_CH(4), .WIDTH(32), .EDGE_MODE(2)) u_both (
    .clk(clk), .rst(rst), .gate(gate), .sig_in(sig_in),
    .count_out(cnt2), .ovf_out(ovf2), .result_valid(rv2), .busy(bz2));
  multi_channel_gated_counter #(.NUM_CH(4), .WIDTH(4), .EDGE_MODE(0)) u_narrow (
    .clk(clk), .rst(rst), .gate(gate), .sig_in(sig_in),
    .count_out(cnt3), .ovf_out(ovf3), .result_valid(rv3), .busy(bz3));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_cnt_vec(input int d);
    logic [127:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (d == 3) v[ch*4 +: 4] = exp_cnt[d][ch][3:0];
      else        v[ch*32 +: 32] = exp_cnt[d][ch][31:0];
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_ovf_vec(input int d);
    logic [3:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = exp_ovf[d][ch];
    return v;
  endfunction

  task automatic check_all();
    chk("rise count_out", cnt0, exp_cnt_vec(0));
    chk("fall count_out", cnt1, exp_cnt_vec(1));
    chk("both count_out", cnt2, exp_cnt_vec(2));
    chk("narrow count_out", 128'(cnt3), exp_cnt_vec(3));
    chk("rise ovf_out", 128'(ovf0), 128'(exp_ovf_vec(0)));
    chk("fall ovf_out", 128'(ovf1), 128'(exp_ovf_vec(1)));
    chk("both ovf_out", 128'(ovf2), 128'(exp_ovf_vec(2)));
    chk("narrow ovf_out", 128'(ovf3), 128'(exp_ovf_vec(3)));
    chk("result_valid", 128'({rv0, rv1, rv2, rv3}), 128'({4{exp_rv}}));
    chk("busy", 128'({bz0, bz1, bz2, bz3}), 128'({4{exp_busy}}));
  endtask

  // Reference: tally edges per window as an unbounded integer, saturate only when reporting.
  task automatic model_step(input logic r, input logic g, input logic [3:0] s);
    logic [3:0] se, rise, fall;
    int e;
    longint w;
    if (r) begin
      m_gprev = 0; m_sprev = '0; m_h1 = '0; m_h2 = '0;
      exp_rv = 0; exp_busy = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        for (int m = 0; m < 3; m++) m_win[m][ch] = 0;
        for (int d = 0; d < 4; d++) begin
          exp_cnt[d][ch] = 0;
          exp_ovf[d][ch] = 0;
        end
      end
    end else begin
`ifdef MULTI_CHANNEL_GATED_COUNTER_SYNC_EN
      se = m_h2; m_h2 = m_h1; m_h1 = s;
`else
      se = s;
`endif
      rise = se & ~m_sprev;
      fall = ~se & m_sprev;
      for (int ch = 0; ch < NCH; ch++) begin
        for (int m = 0; m < 3; m++) begin
          e = (m == 0) ? int'(rise[ch]) : (m == 1) ? int'(fall[ch]) : int'(rise[ch]) + int'(fall[ch]);
          if (g && !m_gprev)     m_win[m][ch] = e;
          else if (g && m_gprev) m_win[m][ch] += e;
        end
      end
      exp_rv = !g && m_gprev;
      if (exp_rv) begin
        for (int d = 0; d < 4; d++) begin
          for (int ch = 0; ch < NCH; ch++) begin
            w = longint'(m_win[D_MODE[d]][ch]);
            exp_cnt[d][ch] = (w > D_MAX[d]) ? D_MAX[d] : w;
            exp_ovf[d][ch] = (w > D_MAX[d]);
          end
        end
      end
      m_gprev = g;
      m_sprev = se;
      exp_busy = g;
    end
  endtask

  task automatic cyc(input logic r, input logic g, input logic [3:0] s);
    @(negedge clk);
    check_all();
    rst = r; gate = g; sig_in = s;
    model_step(r, g, s);
  endtask

  initial begin
    logic [3:0] s;
    logic       g;
    logic       r;
    rst = 1'b1; gate = 1'b0; sig_in = '0;
    model_step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h0);
    s = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, s);

    // 100-cycle window, ch0 toggling every cycle
    for (int i = 0; i < 100; i++) begin s[0] = ~s[0]; cyc(1'b0, 1'b1, s); end
    s = '0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, s);

    // ch1 rising every 2 cycles for 60 cycles saturates the 4-bit variant, then a clean 2-edge window
    for (int i = 0; i < 60; i++) begin s[1] = ~s[1]; cyc(1'b0, 1'b1, s); end
    s = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, s);
    for (int i = 0; i < 10; i++) begin
      s[1] = (i == 2 || i == 3 || i == 6 || i == 7);
      cyc(1'b0, 1'b1, s);
    end
    s = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, s);

    // ch2 square wave of period 4 over 40 cycles
    for (int i = 0; i < 40; i++) begin s[2] = ((i % 4) >= 2); cyc(1'b0, 1'b1, s); end
    s = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, s);

    // reset at cycle 30 of a 100-cycle window with gate held high
    for (int i = 0; i < 100; i++) begin s[0] = ~s[0]; cyc(i == 30, 1'b1, s); end
    s = '0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, s);

    // 1-cycle window with a ch3 edge, 1-cycle gap, then 5 quiet cycles
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b0, 4'b1000);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1000);

    g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) g = ~g;
      r = ($urandom_range(399) == 0);
      s = 4'($urandom);
      cyc(r, g, s);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0);

    @(negedge clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
